// File: rtl/lc3_branch_unit.sv
// LC-3 control-flow unit: resolves BR, JMP/RET and JSR/JSRR over a fixed IDLE->EVAL->LOAD->FIN sequence.
// Optional BR taken/not-taken statistics are compiled in with `define BRANCH_STATS_EN.
module lc3_branch_unit #(
    parameter int DATA_W = 16,
    parameter int IR_W   = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [IR_W-1:0]   ir,
    input  logic              n,
    input  logic              z,
    input  logic              p,
    input  logic [DATA_W-1:0] pc_in,
    input  logic [DATA_W-1:0] base_r,
`ifdef BRANCH_STATS_EN
    input  logic              stat_clr,
    output logic [15:0]       br_taken_cnt,
    output logic [15:0]       br_not_taken_cnt,
`endif
    output logic [DATA_W-1:0] pc_next,
    output logic              ld_pc,
    output logic              r7_we,
    output logic [DATA_W-1:0] r7_data,
    output logic              taken,
    output logic              illegal,
    output logic              done,
    output logic              busy
);

    typedef enum logic [1:0] {S_IDLE, S_EVAL, S_LOAD, S_FIN} state_t;

    localparam logic [3:0] OP_BR  = 4'b0000;
    localparam logic [3:0] OP_JSR = 4'b0100;
    localparam logic [3:0] OP_JMP = 4'b1100;

    state_t state, state_nx;

    logic [IR_W-1:0]   ir_q;
    logic              n_q, z_q, p_q;
    logic [DATA_W-1:0] pc_q;
    logic [DATA_W-1:0] base_q;
    logic [DATA_W-1:0] pc_next_q;
    logic              taken_q, illegal_q, link_q;

    logic [3:0]          opc;
    logic signed [DATA_W-1:0] off9_s, off11_s;
    logic [DATA_W-1:0]   eval_target;
    logic                eval_taken, eval_illegal, eval_link;

    assign opc     = ir_q[IR_W-1 -: 4];
    assign off9_s  = {{(DATA_W-9){ir_q[8]}}, ir_q[8:0]};
    assign off11_s = {{(DATA_W-11){ir_q[10]}}, ir_q[10:0]};

    // EVAL-stage decode; only the registered copy is visible outside
    always_comb begin
        eval_target  = '0;
        eval_taken   = 1'b0;
        eval_illegal = 1'b0;
        eval_link    = 1'b0;
        case (opc)
            OP_BR: begin
                eval_taken  = (ir_q[11] & n_q) | (ir_q[10] & z_q) | (ir_q[9] & p_q);
                eval_target = pc_q + $unsigned(off9_s);
            end
            OP_JMP: begin
                eval_taken  = 1'b1;
                eval_target = base_q;
            end
            OP_JSR: begin
                eval_taken  = 1'b1;
                eval_link   = 1'b1;
                eval_target = ir_q[11] ? (pc_q + $unsigned(off11_s)) : base_q;
            end
            default: eval_illegal = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            ir_q      <= '0;
            n_q       <= 1'b0;
            z_q       <= 1'b0;
            p_q       <= 1'b0;
            pc_q      <= '0;
            base_q    <= '0;
            pc_next_q <= '0;
            taken_q   <= 1'b0;
            illegal_q <= 1'b0;
            link_q    <= 1'b0;
        end else begin
            state <= state_nx;
            if (state == S_IDLE && start) begin
                ir_q   <= ir;
                n_q    <= n;
                z_q    <= z;
                p_q    <= p;
                pc_q   <= pc_in;
                base_q <= base_r;
            end
            if (state == S_EVAL) begin
                pc_next_q <= eval_target;
                taken_q   <= eval_taken;
                illegal_q <= eval_illegal;
                link_q    <= eval_link;
            end
        end
    end

    always_comb begin
        state_nx = state;
        ld_pc    = 1'b0;
        r7_we    = 1'b0;
        done     = 1'b0;
        busy     = (state != S_IDLE);
        case (state)
            S_IDLE: if (start) state_nx = S_EVAL;
            S_EVAL: state_nx = S_LOAD;
            S_LOAD: begin
                ld_pc    = taken_q;
                r7_we    = link_q;
                state_nx = S_FIN;
            end
            S_FIN: begin
                done     = 1'b1;
                state_nx = S_IDLE;
            end
            default: state_nx = S_IDLE;
        endcase
    end

    assign pc_next = pc_next_q;
    assign r7_data = pc_q;
    assign taken   = taken_q;
    assign illegal = illegal_q;

`ifdef BRANCH_STATS_EN
    logic [15:0] taken_cnt_q, not_taken_cnt_q;
    logic        br_fin;

    assign br_fin = (state == S_FIN) && (opc == OP_BR);

    // Saturating counters; clear wins over a same-cycle increment
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            taken_cnt_q     <= '0;
            not_taken_cnt_q <= '0;
        end else if (stat_clr) begin
            taken_cnt_q     <= '0;
            not_taken_cnt_q <= '0;
        end else if (br_fin) begin
            if (taken_q && taken_cnt_q != 16'hFFFF)
                taken_cnt_q <= taken_cnt_q + 16'd1;
            if (!taken_q && not_taken_cnt_q != 16'hFFFF)
                not_taken_cnt_q <= not_taken_cnt_q + 16'd1;
        end
    end

    assign br_taken_cnt     = taken_cnt_q;
    assign br_not_taken_cnt = not_taken_cnt_q;
`endif

endmodule

// File: tb/tb_lc3_branch_unit.sv
// Scoreboard bench for lc3_branch_unit: expected outcomes are queued at start and checked at done.
// Build with +define+BRANCH_STATS_EN to also exercise the statistics counters.
module tb_lc3_branch_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [15:0] ir = '0;
    logic        n = 1'b0, z = 1'b0, p = 1'b0;
    logic [15:0] pc_in = '0, base_r = '0;
    logic [15:0] pc_next, r7_data;
    logic        ld_pc, r7_we, taken, illegal, done, busy;
`ifdef BRANCH_STATS_EN
    logic        stat_clr = 1'b0;
    logic [15:0] br_taken_cnt, br_not_taken_cnt;
`endif

    always #5 clk = ~clk;

    lc3_branch_unit #(.DATA_W(16), .IR_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .ir(ir),
        .n(n), .z(z), .p(p), .pc_in(pc_in), .base_r(base_r),
`ifdef BRANCH_STATS_EN
        .stat_clr(stat_clr), .br_taken_cnt(br_taken_cnt), .br_not_taken_cnt(br_not_taken_cnt),
`endif
        .pc_next(pc_next), .ld_pc(ld_pc), .r7_we(r7_we), .r7_data(r7_data),
        .taken(taken), .illegal(illegal), .done(done), .busy(busy)
    );

    typedef struct {
        logic        taken;
        logic        illegal;
        logic        link;
        logic [15:0] target;
        logic [15:0] link_val;
    } exp_t;

    typedef struct {
        logic [15:0] ir;
        logic [2:0]  nzp;
        logic [15:0] pc;
        logic [15:0] base;
        exp_t        e;
    } case_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    // Observations from the last drive_op window
    int          ld_cnt, r7_cnt, done_cnt, ld_cyc, r7_cyc, done_cyc;
    logic [15:0] ld_val, r7_val;
    logic        tk_v, il_v;

    task automatic drive_op(input case_t c, input logic dbl);
        ld_cnt = 0; r7_cnt = 0; done_cnt = 0;
        ld_cyc = -1; r7_cyc = -1; done_cyc = -1;
        ld_val = '0; r7_val = '0; tk_v = 1'b0; il_v = 1'b0;
        ir = c.ir; {n, z, p} = c.nzp; pc_in = c.pc; base_r = c.base;
        start = 1'b1;
        sb.push_back(c.e);
        for (int cyc = 1; cyc <= 8; cyc++) begin
            @(negedge clk);
            if (cyc == 1) begin
                // Post-capture input changes must not matter
                start = dbl; ir = 16'h1234; {n, z, p} = ~c.nzp;
                pc_in = ~c.pc; base_r = ~c.base;
            end
            if (cyc == 2) start = 1'b0;
            if (ld_pc) begin ld_cnt++; ld_cyc = cyc; ld_val = pc_next; end
            if (r7_we) begin r7_cnt++; r7_cyc = cyc; r7_val = r7_data; end
            if (done) begin done_cnt++; done_cyc = cyc; tk_v = taken; il_v = illegal; end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        n_checks++;
        if ({ld_pc, r7_we, done, busy, taken, illegal} !== 6'b0) begin
            n_fail++; $display("FAIL reset_ctrl: got %b required 000000", {ld_pc, r7_we, done, busy, taken, illegal});
        end
        n_checks++;
        if (pc_next !== 16'h0 || r7_data !== 16'h0) begin
            n_fail++; $display("FAIL reset_data: pc_next=%h r7_data=%h required 0000/0000", pc_next, r7_data);
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_branch();
        case_t tbl[5];
        exp_t  e;
        tbl[0] = '{16'h05FF, 3'b010, 16'h3000, 16'h0000, '{1'b1, 1'b0, 1'b0, 16'h2FFF, 16'h0}};
        tbl[1] = '{16'h0805, 3'b010, 16'h3000, 16'h0000, '{1'b0, 1'b0, 1'b0, 16'h0,    16'h0}};
        tbl[2] = '{16'h0005, 3'b100, 16'h3000, 16'h0000, '{1'b0, 1'b0, 1'b0, 16'h0,    16'h0}};
        tbl[3] = '{16'h0F00, 3'b001, 16'h0000, 16'h0000, '{1'b1, 1'b0, 1'b0, 16'hFF00, 16'h0}};
        tbl[4] = '{16'h02FF, 3'b001, 16'h3000, 16'h0000, '{1'b1, 1'b0, 1'b0, 16'h30FF, 16'h0}};
        for (int i = 0; i < 5; i++) begin
            drive_op(tbl[i], 1'b0);
            e = sb.pop_front();
            n_checks++;
            if (done_cnt !== 1 || done_cyc !== 3) begin
                n_fail++; $display("FAIL br%0d_done: count=%0d cycle=%0d required 1 at 3", i, done_cnt, done_cyc);
            end
            n_checks++;
            if (tk_v !== e.taken || il_v !== 1'b0) begin
                n_fail++; $display("FAIL br%0d_flags: taken=%b illegal=%b required %b/0", i, tk_v, il_v, e.taken);
            end
            n_checks++;
            if (ld_cnt !== (e.taken ? 1 : 0) || (e.taken && (ld_cyc !== 2 || ld_val !== e.target))) begin
                n_fail++; $display("FAIL br%0d_ld: count=%0d cycle=%0d pc=%h required %0d at 2 pc=%h", i, ld_cnt, ld_cyc, ld_val, e.taken, e.target);
            end
            n_checks++;
            if (r7_cnt !== 0) begin
                n_fail++; $display("FAIL br%0d_r7: r7_we pulses=%0d required 0", i, r7_cnt);
            end
        end
    endtask

    task automatic test_subroutine();
        case_t tbl[2];
        exp_t  e;
        tbl[0] = '{16'h4C00, 3'b000, 16'h0100, 16'h0000, '{1'b1, 1'b0, 1'b1, 16'hFD00, 16'h0100}};
        tbl[1] = '{16'h41C0, 3'b000, 16'h5000, 16'h1234, '{1'b1, 1'b0, 1'b1, 16'h1234, 16'h5000}};
        for (int i = 0; i < 2; i++) begin
            drive_op(tbl[i], 1'b0);
            e = sb.pop_front();
            n_checks++;
            if (ld_cnt !== 1 || ld_cyc !== 2 || ld_val !== e.target) begin
                n_fail++; $display("FAIL jsr%0d_ld: count=%0d cycle=%0d pc=%h required 1 at 2 pc=%h", i, ld_cnt, ld_cyc, ld_val, e.target);
            end
            n_checks++;
            if (r7_cnt !== 1 || r7_cyc !== ld_cyc || r7_val !== e.link_val) begin
                n_fail++; $display("FAIL jsr%0d_r7: count=%0d cycle=%0d data=%h required 1 at 2 data=%h", i, r7_cnt, r7_cyc, r7_val, e.link_val);
            end
            n_checks++;
            if (done_cnt !== 1 || done_cyc !== 3 || tk_v !== 1'b1 || il_v !== 1'b0) begin
                n_fail++; $display("FAIL jsr%0d_done: count=%0d cycle=%0d taken=%b illegal=%b required 1 at 3, 1/0", i, done_cnt, done_cyc, tk_v, il_v);
            end
        end
    endtask

    task automatic test_ret_busy();
        case_t c;
        exp_t  e;
        c = '{16'hC1C0, 3'b000, 16'h3000, 16'h4567, '{1'b1, 1'b0, 1'b0, 16'h4567, 16'h0}};
        drive_op(c, 1'b1);
        e = sb.pop_front();
        n_checks++;
        if (ld_cnt !== 1 || ld_val !== e.target) begin
            n_fail++; $display("FAIL ret_ld: count=%0d pc=%h required 1 pc=%h", ld_cnt, ld_val, e.target);
        end
        n_checks++;
        if (r7_cnt !== 0) begin
            n_fail++; $display("FAIL ret_r7: r7_we pulses=%0d required 0", r7_cnt);
        end
        n_checks++;
        if (done_cnt !== 1 || done_cyc !== 3) begin
            n_fail++; $display("FAIL ret_single_done: count=%0d cycle=%0d required 1 at 3", done_cnt, done_cyc);
        end
    endtask

    task automatic test_illegal();
        case_t c;
        exp_t  e;
        c = '{16'h1234, 3'b111, 16'h3000, 16'hABCD, '{1'b0, 1'b1, 1'b0, 16'h0, 16'h0}};
        drive_op(c, 1'b0);
        e = sb.pop_front();
        n_checks++;
        if (done_cnt !== 1 || done_cyc !== 3 || tk_v !== e.taken || il_v !== e.illegal) begin
            n_fail++; $display("FAIL illegal_done: count=%0d cycle=%0d taken=%b illegal=%b required 1 at 3, 0/1", done_cnt, done_cyc, tk_v, il_v);
        end
        n_checks++;
        if (ld_cnt !== 0 || r7_cnt !== 0) begin
            n_fail++; $display("FAIL illegal_strobes: ld=%0d r7=%0d required 0/0", ld_cnt, r7_cnt);
        end
    endtask

`ifdef BRANCH_STATS_EN
    task automatic test_stats();
        n_checks++;
        if (br_taken_cnt !== 16'd3 || br_not_taken_cnt !== 16'd2) begin
            n_fail++; $display("FAIL stats_count: taken=%0d not_taken=%0d required 3/2", br_taken_cnt, br_not_taken_cnt);
        end
        stat_clr = 1'b1;
        @(negedge clk);
        stat_clr = 1'b0;
        n_checks++;
        if (br_taken_cnt !== 16'd0 || br_not_taken_cnt !== 16'd0) begin
            n_fail++; $display("FAIL stats_clear: taken=%0d not_taken=%0d required 0/0", br_taken_cnt, br_not_taken_cnt);
        end
    endtask
`endif

    task automatic test_back_to_back();
        int dc[$];
        int lc;
        ir = 16'h05FF; {n, z, p} = 3'b010; pc_in = 16'h3000; base_r = 16'h0;
        start = 1'b1;
        lc = 0;
        for (int cyc = 1; cyc <= 8; cyc++) begin
            @(negedge clk);
            if (cyc == 5) start = 1'b0;
            if (done) dc.push_back(cyc);
            if (ld_pc && pc_next === 16'h2FFF) lc++;
        end
        n_checks++;
        if (dc.size() !== 2 || dc[0] !== 3 || dc[1] !== 7) begin
            n_fail++; $display("FAIL b2b_done: pulses=%0d first=%0d second=%0d required 2 at 3 and 7", dc.size(),
                               dc.size() > 0 ? dc[0] : -1, dc.size() > 1 ? dc[1] : -1);
        end
        n_checks++;
        if (lc !== 2) begin
            n_fail++; $display("FAIL b2b_ld: pc loads=%0d required 2", lc);
        end
    endtask

    task automatic test_abort();
        case_t c;
        exp_t  e;
        int    dcnt, scnt;
        ir = 16'h4C00; {n, z, p} = 3'b000; pc_in = 16'h0100; base_r = 16'h0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        n_checks++;
        if (ld_pc !== 1'b1 || r7_we !== 1'b1) begin
            n_fail++; $display("FAIL abort_in_load: ld_pc=%b r7_we=%b required 1/1", ld_pc, r7_we);
        end
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({ld_pc, r7_we, done, busy, taken, illegal} !== 6'b0 || pc_next !== 16'h0 || r7_data !== 16'h0) begin
            n_fail++; $display("FAIL abort_outputs: ctrl=%b pc_next=%h r7_data=%h required 000000/0000/0000",
                               {ld_pc, r7_we, done, busy, taken, illegal}, pc_next, r7_data);
        end
        dcnt = 0; scnt = 0;
        repeat (3) begin
            @(negedge clk);
            if (done) dcnt++;
            if (ld_pc || r7_we) scnt++;
        end
        rst_n = 1'b1;
        repeat (4) begin
            @(negedge clk);
            if (done) dcnt++;
            if (ld_pc || r7_we || busy) scnt++;
        end
        n_checks++;
        if (dcnt !== 0 || scnt !== 0) begin
            n_fail++; $display("FAIL abort_no_done: done=%0d strobes=%0d required 0/0", dcnt, scnt);
        end
`ifdef BRANCH_STATS_EN
        n_checks++;
        if (br_taken_cnt !== 16'd0 || br_not_taken_cnt !== 16'd0) begin
            n_fail++; $display("FAIL abort_stats: taken=%0d not_taken=%0d required 0/0", br_taken_cnt, br_not_taken_cnt);
        end
`endif
        c = '{16'hC1C0, 3'b000, 16'h3000, 16'h0ACE, '{1'b1, 1'b0, 1'b0, 16'h0ACE, 16'h0}};
        drive_op(c, 1'b0);
        e = sb.pop_front();
        n_checks++;
        if (done_cnt !== 1 || done_cyc !== 3 || ld_cnt !== 1 || ld_val !== e.target) begin
            n_fail++; $display("FAIL abort_recover: done=%0d at %0d ld=%0d pc=%h required 1 at 3, 1, %h",
                               done_cnt, done_cyc, ld_cnt, ld_val, e.target);
        end
    endtask

    initial begin
        test_reset();
        test_branch();
        test_subroutine();
        test_ret_busy();
        test_illegal();
`ifdef BRANCH_STATS_EN
        test_stats();
`endif
        test_back_to_back();
        test_abort();
        n_checks++;
        if (sb.size() !== 0) begin
            n_fail++; $display("FAIL scoreboard_drain: %0d entries left, required 0", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time budget");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/lc3_branch_unit.md
Name: lc3_branch_unit

Overview:
- Parametrised, clocked control-flow unit for the LC-3 datapath.
- Generalises conditional-branch handling to BR, JMP/RET and JSR/JSRR.
- Fixed-latency FSM with a start/done handshake. Computes the next PC, drives the PC load strobe and the R7 link write.
- Sits between the control FSM (start/done) and the PC/register-file write ports.

Parameters:
- DATA_W, 16: PC and register width (≥16); all target arithmetic at this width.
- IR_W, 16: instruction width; opcode is IR[IR_W-1:IR_W-4].

Ports:
- clk  in  1  system clock, all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  one-cycle request; sampled only in IDLE
- ir  in  IR_W  instruction, captured on accepted start
- n, z, p  in  1 each  condition codes, captured on accepted start
- pc_in  in  DATA_W  already-incremented PC, captured on accepted start
- base_r  in  DATA_W  BaseR register value (JMP/JSRR), captured on accepted start
- pc_next  out  DATA_W  computed target; valid while ld_pc=1
- ld_pc  out  1  one-cycle PC load strobe
- r7_we  out  1  one-cycle link write strobe (JSR/JSRR)
- r7_data  out  DATA_W  link value (captured pc_in)
- taken  out  1  result flag, valid with done
- illegal  out  1  opcode not handled, valid with done
- done  out  1  one-cycle completion pulse
- busy  out  1  high in every state except IDLE

Behaviour:
- Reset: state=IDLE; all outputs 0; captured registers 0. Asserting rst_n low in any state aborts immediately. No ld_pc, r7_we or done is emitted for an aborted operation.
- FSM states: IDLE -> EVAL -> LOAD -> FIN -> IDLE.
- IDLE: start=1 captures ir, n, z, p, pc_in and base_r, then goes to EVAL. start in any other state is ignored, not queued.
- EVAL (cycle 1): decode and register pc_next/taken/illegal as follows.
  - BR (0000): taken = (ir[11]&n)|(ir[10]&z)|(ir[9]&p). nzp=000 is never taken; nzp=111 is always taken. Target = pc + sext(ir[8:0]).
  - JMP/RET (1100): taken=1, target = base_r.
  - JSR (0100, ir[11]=1): taken=1, target = pc + sext(ir[10:0]).
  - JSRR (0100, ir[11]=0): taken=1, target = base_r.
  - Any other opcode: taken=0, illegal=1.
- LOAD (cycle 2):
  - ld_pc=taken.
  - r7_we=1 for JSR/JSRR only, with r7_data = captured pc_in. Link value is the pre-jump PC even when base_r is R7.
- FIN (cycle 3): done=1 for one cycle; taken and illegal held valid this cycle. Then IDLE; start may be accepted on the next cycle.
- Latency: done exactly 3 cycles after the start-sample edge, regardless of outcome. Back-to-back throughput is 1 op per 4 cycles.
- Arithmetic: offsets sign-extended to DATA_W; sum is modulo 2^DATA_W (wrap-around, no overflow flag).
- pc_next holds its value from EVAL until the next accepted start; it is 0 after reset.
- Condition-code changes after capture have no effect.

Optional Feature:
- Macro BRANCH_STATS_EN.
- When defined, adds ports:
  - stat_clr (in, 1): synchronous clear.
  - br_taken_cnt (out, 16)
  - br_not_taken_cnt (out, 16)
- Counter rules:
  - Counters count BR opcodes only, incrementing in FIN.
  - Counters saturate at 0xFFFF.
  - stat_clr has priority over increment.
  - Counters reset to 0 on rst_n.
- When undefined: ports and counters are absent. Core behaviour is identical.

Test Plan:
- BRz, ir=0x05FF, z=1, pc_in=0x3000 -> ld_pc=1 at cycle 2 with pc_next=0x2FFF; done at cycle 3; taken=1.
- BRn, ir=0x0805, z=1 -> ld_pc stays 0, r7_we stays 0; done at cycle 3; taken=0. Repeat with ir=0x0005 (nzp=000) and n=1 -> taken=0.
- JSR, ir=0x4C00 (offset -1024), pc_in=0x0100 -> pc_next=0xFD00 (wrap), r7_we=1 with r7_data=0x0100 in the same cycle as ld_pc.
- RET, ir=0xC1C0, base_r=0x4567 -> pc_next=0x4567, ld_pc=1, r7_we=0. Second start pulse during busy is ignored: exactly one done.
- Illegal, ir=0x1234 -> illegal=1, taken=0, no ld_pc; done at cycle 3. Reset: assert rst_n=0 in LOAD -> all outputs 0 immediately, no done; a fresh start afterwards completes normally.
- BRANCH_STATS_EN: 3 taken and 2 untaken BRs plus 1 JSR -> br_taken_cnt=3, br_not_taken_cnt=2. Then stat_clr=1 -> both 0.
